// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// spi_reg_ctrl : SPI command/data frame sequencer driving MIDI routing regs
// Rev 1.0
// ============================================================================
module spi_reg_ctrl #(
    parameter int NREG        = 8,
    parameter int IDLE_CYCLES = 256
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                spi_clk,
    input  logic [7:0]          sr_byte,
    output logic [7:0]          tx_byte,
    output logic                tx_load,
    output logic [NREG*8-1:0]   route_regs,
    output logic                wr_strobe,
    output logic [2:0]          wr_index,
    output logic                frame_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [15:0] C_IDLE_MAX = 16'(IDLE_CYCLES);

    state_t              r_state;
    logic                r_sync1, r_sync2, r_sync3;
    logic [2:0]          r_bit_cnt;
    logic [15:0]         r_idle_cnt;
    logic [2:0]          r_cmd_idx;
    logic                r_cmd_rd;
    logic                r_cmd_valid;
    logic [NREG*8-1:0]   r_route_regs;
    logic [7:0]          r_tx_byte;
    logic                r_tx_load;
    logic                r_wr_strobe;
    logic [2:0]          r_wr_index;
    logic                r_frame_err;
    logic                r_busy;

    logic                w_rise;
    logic                w_bc;
    logic                w_to;
    logic                w_valid;
    logic [7:0]          w_rd_data;

    assign w_rise  = r_sync2 & ~r_sync3;
    assign w_bc    = w_rise && (r_bit_cnt == 3'd7);
    // A rise in the same cycle pre-empts the timeout.
    assign w_to    = (r_idle_cnt == C_IDLE_MAX) && !w_rise &&
                     ((r_state != S_IDLE) || (r_bit_cnt != 3'd0));
    assign w_valid = (sr_byte[6:3] == 4'd0) && (32'(sr_byte[2:0]) < NREG);

    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            if (sr_byte[2:0] == 3'(i)) w_rd_data = r_route_regs[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync3      <= 1'b1;
            r_bit_cnt    <= 3'd0;
            r_idle_cnt   <= 16'd0;
            r_cmd_idx    <= 3'd0;
            r_cmd_rd     <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_route_regs <= '0;
            r_tx_byte    <= 8'h00;
            r_tx_load    <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_index   <= 3'd0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync1     <= spi_clk;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_tx_load   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_rise) begin
                r_idle_cnt <= 16'd0;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end else if (r_idle_cnt != C_IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end

            if (w_to) begin
                r_frame_err <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            r_state <= S_CMD;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (w_bc) begin
                            r_cmd_idx   <= sr_byte[2:0];
                            r_cmd_rd    <= sr_byte[7];
                            r_cmd_valid <= w_valid;
                            r_tx_byte   <= (sr_byte[7] && w_valid) ? w_rd_data : 8'h00;
                            r_tx_load   <= 1'b1;
                            r_state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_bc) begin
                            if (r_cmd_valid && !r_cmd_rd) begin
                                for (int i = 0; i < NREG; i++) begin
                                    if (r_cmd_idx == 3'(i)) r_route_regs[i*8 +: 8] <= sr_byte;
                                end
                                r_wr_strobe <= 1'b1;
                                r_wr_index  <= r_cmd_idx;
                            end else if (!r_cmd_valid) begin
                                r_frame_err <= 1'b1;
                            end
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_byte    = r_tx_byte;
    assign tx_load    = r_tx_load;
    assign route_regs = r_route_regs;
    assign wr_strobe  = r_wr_strobe;
    assign wr_index   = r_wr_index;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_ctrl : scoreboard bench for spi_reg_ctrl (NREG=8 and NREG=4 DUTs)
// Rev 1.0
// ============================================================================
module tb_spi_reg_ctrl;

    localparam int IDLE = 40;
    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        spi_clk = 1'b1;
    logic        mosi = 1'b0;
    logic [7:0]  sr = 8'h00;

    logic [7:0]  tx8, tx4;
    logic        ld8, ld4, ws8, ws4, fe8, fe4, bz8, bz4;
    logic [2:0]  wi8, wi4;
    logic [63:0] rr8;
    logic [31:0] rr4;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shiftreg: MSB-first shift on spi_clk rise.
    always @(posedge spi_clk) sr <= {sr[6:0], mosi};

    spi_reg_ctrl #(.NREG(8), .IDLE_CYCLES(IDLE)) u_dut (
        .clk(clk), .nreset(nreset), .spi_clk(spi_clk), .sr_byte(sr),
        .tx_byte(tx8), .tx_load(ld8), .route_regs(rr8), .wr_strobe(ws8),
        .wr_index(wi8), .frame_err(fe8), .busy(bz8));

    spi_reg_ctrl #(.NREG(4), .IDLE_CYCLES(IDLE)) u_dut4 (
        .clk(clk), .nreset(nreset), .spi_clk(spi_clk), .sr_byte(sr),
        .tx_byte(tx4), .tx_load(ld4), .route_regs(rr4), .wr_strobe(ws4),
        .wr_index(wi4), .frame_err(fe4), .busy(bz4));

    typedef struct { logic [2:0] idx; logic [7:0] data; } wr_t;
    wr_t        q_wr8[$], q_wr4[$];
    logic [7:0] q_tx8[$], q_tx4[$];
    int         exp_err8 = 0, exp_err4 = 0;
    logic [7:0] model8 [8];
    logic [7:0] model4 [4];
    int         n_checks = 0, n_fails = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (nreset) begin
            if (ld8) begin
                check("tx_load8 queued", 64'(q_tx8.size() > 0), 64'd1);
                if (q_tx8.size() > 0) check("tx_byte8", 64'(tx8), 64'(q_tx8.pop_front()));
            end
            if (ld4) begin
                check("tx_load4 queued", 64'(q_tx4.size() > 0), 64'd1);
                if (q_tx4.size() > 0) check("tx_byte4", 64'(tx4), 64'(q_tx4.pop_front()));
            end
            if (ws8) begin
                check("wr_strobe8 queued", 64'(q_wr8.size() > 0), 64'd1);
                if (q_wr8.size() > 0) begin
                    wr_t w;
                    w = q_wr8.pop_front();
                    check("wr_index8", 64'(wi8), 64'(w.idx));
                    check("wr_data8", 64'(rr8[{w.idx, 3'b000} +: 8]), 64'(w.data));
                end
            end
            if (ws4) begin
                check("wr_strobe4 queued", 64'(q_wr4.size() > 0), 64'd1);
                if (q_wr4.size() > 0) begin
                    wr_t w;
                    w = q_wr4.pop_front();
                    check("wr_index4", 64'(wi4), 64'(w.idx));
                    check("wr_data4", 64'(rr4[{w.idx[1:0], 3'b000} +: 8]), 64'(w.data));
                end
            end
            if (fe8) begin
                check("frame_err8 expected", 64'(exp_err8 > 0), 64'd1);
                if (exp_err8 > 0) exp_err8--;
            end
            if (fe4) begin
                check("frame_err4 expected", 64'(exp_err4 > 0), 64'd1);
                if (exp_err4 > 0) exp_err4--;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        spi_clk = 1'b0;
        mosi    = b;
        #HALF;
        spi_clk = 1'b1;
        #HALF;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
    endtask

    // Queue the responses a complete two-byte frame should produce.
    task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] data, input logic full);
        logic [2:0] idx;
        logic       rd, ok8, ok4;
        idx = cmd[2:0];
        rd  = cmd[7];
        ok8 = (cmd[6:3] == 4'd0);
        ok4 = ok8 && (idx < 3'd4);
        q_tx8.push_back((rd && ok8) ? model8[idx] : 8'h00);
        q_tx4.push_back((rd && ok4) ? model4[idx[1:0]] : 8'h00);
        if (full) begin
            if (ok8 && !rd) begin q_wr8.push_back('{idx, data}); model8[idx] = data; end
            if (!ok8) exp_err8++;
            if (ok4 && !rd) begin q_wr4.push_back('{idx, data}); model4[idx[1:0]] = data; end
            if (!ok4) exp_err4++;
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data);
        expect_frame(cmd, data, 1'b1);
        send_bits(cmd, 8);
        send_bits(data, 8);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model8[i] = 8'h00;
        for (int i = 0; i < 4; i++) model4[i] = 8'h00;

        wait_clk(5);
        check("reset route_regs8", rr8, 64'h0);
        check("reset route_regs4", 64'(rr4), 64'h0);
        check("reset tx_byte8", 64'(tx8), 64'h00);
        check("reset strobes8", 64'({ld8, ws8, fe8, bz8}), 64'h0);
        check("reset wr_index8", 64'(wi8), 64'h0);
        nreset = 1'b1;
        wait_clk(5);

        // Write 0xA5 to reg1, then read it back.
        send_frame(8'h01, 8'hA5);
        wait_clk(10);
        check("busy8 after write", 64'(bz8), 64'd0);
        check("regs8 after write", rr8, 64'h0000_0000_0000_A500);
        send_frame(8'h81, 8'h00);
        wait_clk(10);
        check("regs8 after read", rr8, 64'h0000_0000_0000_A500);

        // Back-to-back sweep of all eight registers.
        for (int i = 0; i < 8; i++) send_frame(8'(i), 8'(1 << i));
        wait_clk(10);
        check("regs8 sweep", rr8, 64'h8040_2010_0804_0201);
        check("regs4 sweep", 64'(rr4), 64'h0804_0201);

        // Invalid frames: index beyond NREG=4, and nonzero reserved bits.
        send_frame(8'h05, 8'h3C);
        send_frame(8'h41, 8'h3C);
        wait_clk(10);
        check("regs4 invalid", 64'(rr4), 64'h0804_0201);
        check("regs8 invalid", rr8, 64'h8040_3C10_0804_0201);

        // Timeout after a lone command byte, then re-alignment.
        expect_frame(8'h02, 8'h00, 1'b0);
        exp_err8++;
        exp_err4++;
        send_bits(8'h02, 8);
        wait_clk(IDLE + 20);
        check("busy8 after timeout", 64'(bz8), 64'd0);
        check("busy4 after timeout", 64'(bz4), 64'd0);
        send_frame(8'h02, 8'h77);
        wait_clk(10);
        check("reg2 after timeout", 64'(rr8[23:16]), 64'h77);

        // Timeout after three stray bits, then a clean frame.
        exp_err8++;
        exp_err4++;
        send_bits(8'hE0, 3);
        wait_clk(IDLE + 20);
        send_frame(8'h00, 8'h11);
        wait_clk(10);
        check("reg0 after partial", 64'(rr8[7:0]), 64'h11);
        check("reg0_4 after partial", 64'(rr4[7:0]), 64'h11);

        // Reset in the middle of the data byte.
        expect_frame(8'h03, 8'hFF, 1'b0);
        send_bits(8'h03, 8);
        send_bits(8'hFF, 3);
        wait_clk(6);
        check("busy8 mid-frame", 64'(bz8), 64'd1);
        nreset = 1'b0;
        wait_clk(3);
        check("mid reset route_regs8", rr8, 64'h0);
        check("mid reset route_regs4", 64'(rr4), 64'h0);
        check("mid reset tx_byte8", 64'(tx8), 64'h00);
        check("mid reset outs8", 64'({ld8, ws8, fe8, bz8, wi8}), 64'h0);
        for (int i = 0; i < 8; i++) model8[i] = 8'h00;
        for (int i = 0; i < 4; i++) model4[i] = 8'h00;
        nreset = 1'b1;
        wait_clk(5);
        send_frame(8'h03, 8'h5A);
        wait_clk(20);
        check("regs8 after reset", rr8, 64'h0000_0000_5A00_0000);
        check("regs4 after reset", 64'(rr4), 64'h5A00_0000);

        check("pending tx8", 64'(q_tx8.size()), 64'd0);
        check("pending tx4", 64'(q_tx4.size()), 64'd0);
        check("pending wr8", 64'(q_wr8.size()), 64'd0);
        check("pending wr4", 64'(q_wr4.size()), 64'd0);
        check("pending err8", 64'(exp_err8), 64'd0);
        check("pending err4", 64'(exp_err4), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
